// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO write-port arbiter: default sizes, state
// encoding and the index-width helper used for owner/last registers.
package fifo_pkg;

  localparam int NREQ  = 4;
  localparam int DSIZE = 32;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // A single producer still needs a 1-bit index so port widths never collapse.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDXW = idx_w(NREQ);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first candidate at last+1, last+2, ...
// modulo N, where candidates are the request bits not masked by excl.
module rr_pick #(
  parameter int N  = fifo_pkg::NREQ,
  parameter int IW = fifo_pkg::idx_w(fifo_pkg::NREQ)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic [N-1:0]  excl,
  output logic [IW-1:0] winner,
  output logic          found
);

  logic [N-1:0] cand;

  assign cand = req & ~excl;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && cand[(int'(last) + k) % N]) begin
        winner = IW'((int'(last) + k) % N);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers,
// granting bursts of up to MAX_BURST words with same-cycle hand-over.
module fifo_wr_arb #(
  parameter int NREQ      = fifo_pkg::NREQ,
  parameter int DSIZE     = fifo_pkg::DSIZE,
  parameter int MAX_BURST = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req,
  input  logic [NREQ*DSIZE-1:0]                req_data,
  output logic [NREQ-1:0]                      ack,
  input  logic                                 wfull,
  output logic                                 winc,
  output logic [DSIZE-1:0]                     wdata,
  output logic [fifo_pkg::idx_w(NREQ)-1:0]     owner,
  output logic                                 busy
);
  import fifo_pkg::*;

  localparam int IW = idx_w(NREQ);

  // Handshake: a word moves when ack[i] is high; the producer must hold req[i]
  // and its data slice stable until then. No data is stored here.
  logic [0:0]      state;
  logic [IW-1:0]   last;
  logic [3:0]      count;
  logic            req_own;
  logic            xfer;
  logic            rel;
  logic            found;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   pick_last;
  logic [NREQ-1:0] own_oh;
  logic [NREQ-1:0] excl;

  assign own_oh  = {{(NREQ-1){1'b0}}, 1'b1} << owner;
  assign req_own = req[owner];
  assign busy    = (state == GRANT);
  assign xfer    = busy && req_own && !wfull;
  assign winc    = xfer;
  assign ack     = xfer ? own_oh : '0;
  assign wdata   = busy ? req_data[owner*DSIZE +: DSIZE] : '0;

  // The count is compared one bit wider so MAX_BURST=16 still terminates.
  assign rel = busy && ((xfer && (({1'b0, count} + 5'd1) == 5'(MAX_BURST))) || !req_own);

  // On release the outgoing owner becomes "last"; it is skipped unless alone.
  assign pick_last = busy ? owner : last;
  assign excl      = (busy && |(req & ~own_oh)) ? own_oh : '0;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .last   (pick_last),
    .excl   (excl),
    .winner (winner),
    .found  (found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      count <= '0;
      last  <= IW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            owner <= winner;
            count <= '0;
          end
        end
        default: begin
          if (rel) begin
            last  <= owner;
            count <= '0;
            if (found) owner <= winner;
            else       state <= IDLE;
          end else if (xfer) begin
            count <= count + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: cycle vectors with expected grant/write outputs and a
// write-data scoreboard, plus a MAX_BURST=1 rotation sequence.
module tb_fifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int DSIZE = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*DSIZE-1:0]  req_data;
  logic                   wfull;
  logic [NREQ-1:0]        ack,   ack1;
  logic                   winc,  winc1;
  logic [DSIZE-1:0]       wdata, wdata1;
  logic [1:0]             owner, owner1;
  logic                   busy,  busy1;

  fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .wfull(wfull), .winc(winc), .wdata(wdata), .owner(owner), .busy(busy)
  );

  fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack1),
    .wfull(wfull), .winc(winc1), .wdata(wdata1), .owner(owner1), .busy(busy1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       wf;
    logic       e_busy;
    int         e_owner;   // -1: owner not checked
    logic       e_winc;
  } vec_t;

  vec_t              vecs[$];
  logic [DSIZE-1:0]  exp_q[$];
  int                wcnt[NREQ];
  int                n_tests;
  int                n_fail;

  function automatic logic [DSIZE-1:0] data_of(input int o);
    return {8'(8'hA0 + o), 24'(wcnt[o])};
  endfunction

  // driver tasks
  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = data_of(i);
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic wf,
                     input logic b, input int o, input logic w);
    vec_t v;
    v.rst = r; v.req = rq; v.wf = wf; v.e_busy = b; v.e_owner = o; v.e_winc = w;
    vecs.push_back(v);
  endtask

  task automatic burst(input int o, input int n, input logic [3:0] rq);
    for (int i = 0; i < n; i++) add(1'b0, rq, 1'b0, 1'b1, o, 1'b1);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t       v;
    logic [3:0] ea;
    rst = 1'b1; req = '0; wfull = 1'b0; req_data = '0;
    n_tests = 0; n_fail = 0;
    for (int i = 0; i < NREQ; i++) wcnt[i] = 0;

    // single producer: 4 words, re-grant without gap, 2 more words
    add(0, 4'b0001, 0, 0, 0, 0);
    burst(0, 6, 4'b0001);
    add(0, 4'b0000, 0, 1, 0, 0);
    add(0, 4'b0000, 0, 0, -1, 0);
    // all four requesting: order 0,1,2,3,0 with back-to-back bursts
    add(1, 4'b0000, 0, 0, -1, 0);
    add(0, 4'b1111, 0, 0, 0, 0);
    burst(0, 4, 4'b1111); burst(1, 4, 4'b1111); burst(2, 4, 4'b1111);
    burst(3, 4, 4'b1111); burst(0, 4, 4'b1111);
    add(0, 4'b0000, 0, 1, 1, 0);
    add(0, 4'b0000, 0, 0, -1, 0);
    // wfull stall in the middle of the owner-2 burst
    add(1, 4'b0000, 0, 0, -1, 0);
    add(0, 4'b1111, 0, 0, 0, 0);
    burst(0, 4, 4'b1111); burst(1, 4, 4'b1111); burst(2, 2, 4'b1111);
    for (int i = 0; i < 3; i++) add(0, 4'b1111, 1, 1, 2, 0);
    burst(2, 2, 4'b1111); burst(3, 1, 4'b1111);
    add(0, 4'b0000, 0, 1, 3, 0);
    add(0, 4'b0000, 0, 0, -1, 0);
    // owner 1 drops after 2 words while producer 3 waits
    add(1, 4'b0000, 0, 0, -1, 0);
    add(0, 4'b1010, 0, 0, 0, 0);
    burst(1, 2, 4'b1010);
    add(0, 4'b1000, 0, 1, 1, 0);
    add(0, 4'b1000, 0, 1, 3, 1);
    add(0, 4'b0000, 0, 1, 3, 0);
    add(0, 4'b0000, 0, 0, -1, 0);
    // owner drops req while the FIFO is full
    add(1, 4'b0000, 0, 0, -1, 0);
    add(0, 4'b0001, 0, 0, 0, 0);
    add(0, 4'b0001, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 0, 0);
    add(0, 4'b0000, 0, 0, -1, 0);
    // reset during the owner-1 burst
    add(1, 4'b0000, 0, 0, -1, 0);
    add(0, 4'b1111, 0, 0, 0, 0);
    burst(0, 4, 4'b1111); burst(1, 2, 4'b1111);
    add(1, 4'b1111, 1, 1, 1, 0);
    add(0, 4'b1111, 0, 0, 0, 0);
    burst(0, 2, 4'b1111);
    add(0, 4'b0000, 0, 1, 0, 0);
    add(0, 4'b0000, 0, 0, -1, 0);

    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      rst = v.rst; req = v.req; wfull = v.wf;
      drive_data();
      #1;
      ea = v.e_winc ? (4'b0001 << v.e_owner) : 4'b0000;
      check($sformatf("v%0d busy", i), 64'(busy), 64'(v.e_busy));
      check($sformatf("v%0d winc", i), 64'(winc), 64'(v.e_winc));
      check($sformatf("v%0d ack", i),  64'(ack),  64'(ea));
      if (v.e_owner >= 0) check($sformatf("v%0d owner", i), 64'(owner), 64'(v.e_owner));
      check($sformatf("v%0d wdata", i), 64'(wdata),
            v.e_busy ? 64'(data_of(v.e_owner)) : 64'd0);
      if (v.e_winc) exp_q.push_back(data_of(v.e_owner));
      if (winc) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL v%0d sb_unexpected_write: got %0h expected none", i, wdata);
        end else begin
          check($sformatf("v%0d sb_data", i), 64'(wdata), 64'(exp_q.pop_front()));
        end
      end
      if (v.e_winc) wcnt[v.e_owner]++;
    end
    check("sb_drain", 64'(exp_q.size()), 64'd0);

    // MAX_BURST=1: one word per grant, owner rotates every cycle
    @(negedge clk);
    rst = 1'b1; req = 4'b1111; wfull = 1'b0;
    drive_data();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mb1 idle busy", 64'(busy1), 64'd0);
    check("mb1 idle winc", 64'(winc1), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive_data();
      #1;
      check($sformatf("mb1 k%0d busy", k),  64'(busy1),  64'd1);
      check($sformatf("mb1 k%0d owner", k), 64'(owner1), 64'(k % 4));
      check($sformatf("mb1 k%0d winc", k),  64'(winc1),  64'd1);
      check($sformatf("mb1 k%0d ack", k),   64'(ack1),   64'(4'b0001 << (k % 4)));
      check($sformatf("mb1 k%0d wdata", k), 64'(wdata1), 64'(data_of(k % 4)));
      wcnt[k % 4]++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NREQ, default 4, number of producers sharing the FIFO write port.
REQ-002 Parameter DSIZE, default 32, data word width, matching the FIFO write data width.
REQ-003 Parameter MAX_BURST, default 4, maximum words per grant (range 1..16).
REQ-004 Port clk, input, 1, the single clock; it is the FIFO write clock (wclk).
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port req, input, NREQ, per-producer valid: producer i holds a word on its data slice.
REQ-007 Port req_data, input, NREQ*DSIZE, producer i data at bits [i*DSIZE +: DSIZE].
REQ-008 Port ack, output, NREQ, one-hot-or-zero; ack[i]=1 means the word of producer i is written this cycle.
REQ-009 Port wfull, input, 1, FIFO full flag, synchronous to clk.
REQ-010 Port winc, output, 1, FIFO write enable.
REQ-011 Port wdata, output, DSIZE, FIFO write data.
REQ-012 Port owner, output, clog2(NREQ), index of the current grant holder.
REQ-013 Port busy, output, 1, high while a grant is held.

Function
REQ-014 Two states: IDLE (no grant) and GRANT (owner register valid).
REQ-015 In IDLE with any req bit set, the arbiter SHALL choose the winner round-robin: first set req at index last+1, last+2, ... modulo NREQ.
- It loads owner, clears the burst count, and enters GRANT on the next edge.
- No ack is issued during this arbitration cycle, so first-grant latency is 1 cycle.
REQ-016 In GRANT, winc = ack[owner] = req[owner] AND NOT wfull, combinational from the registered owner and current inputs; all other ack bits SHALL be 0.
REQ-017 In GRANT, wdata SHALL equal the req_data slice of owner; in IDLE, wdata SHALL be 0.
REQ-018 Each transfer (winc=1) SHALL increment the burst count, which is a 4-bit counter.
REQ-019 The grant SHALL be released at the clock edge on which either of these holds:
- a transfer brings the count to MAX_BURST; or
- req[owner]=0.
REQ-020 On release, last SHALL take the value of owner, and re-arbitration SHALL happen in the same cycle, excluding owner unless it is the only requester.
- If a winner exists, the arbiter stays in GRANT with the new owner and a cleared count, with no idle gap.
- Otherwise it goes to IDLE.
REQ-021 wfull=1 with req[owner]=1 SHALL stall the transfer: no winc, count held, grant held, no timeout.
REQ-022 req[owner] falling while wfull=1 SHALL release the grant per REQ-019.
REQ-023 A producer SHALL keep req and data stable until acked; the arbiter does not buffer data (zero storage).
REQ-024 busy SHALL be 1 exactly when the state is GRANT.
REQ-025 With MAX_BURST=1, the arbiter SHALL rotate after every word.

Reset
REQ-026 When rst=1 at a clock edge, the following SHALL hold:
- state = IDLE, owner = 0, count = 0, last = NREQ-1, so producer 0 has first priority;
- busy, winc and ack are 0, and wdata = 0.
REQ-027 Reset SHALL override any grant in progress; no winc is asserted in the cycle after reset is sampled.

Structure
REQ-028 A shared package (fifo_pkg) SHALL hold DSIZE, NREQ, the state encoding (IDLE=0, GRANT=1) and a clog2-based index width constant.
REQ-029 The round-robin priority pick SHALL be a sub-module, rr_pick.
- It is purely combinational.
- Inputs: request vector, last index, exclude mask.
- Outputs: winner index and found flag.

Verification
REQ-030 Single producer: req=4'b0001 for 6 words, wfull=0.
- Expected: grant at cycle 1; 4 acks; release; re-grant to 0 with no gap; 2 more acks.
REQ-031 All four producers request continuously with MAX_BURST=4.
- Expected grant order 0,1,2,3,0; each holds exactly 4 consecutive winc cycles; no idle cycle between owners.
REQ-032 wfull stall: wfull=1 for 3 cycles in the middle of the owner-2 burst.
- Expected: winc=0 and count frozen during the stall.
- Owner stays 2, and the burst completes with 4 words total.
REQ-033 Owner drop: owner 1 deasserts req after 2 words while req[3]=1.
- Expected: the next cycle has owner=3, and only 2 words come from producer 1.
REQ-034 Reset mid-burst: rst pulsed during the owner-1 burst.
- Expected: next cycle busy=0 and winc=0.
- With all producers requesting, the next grant goes to 0.
